serial_subtractor: RTL

Bit-serial two's-complement subtractor computing A − B one bit per clock, LSB first, with a single borrow flip-flop carried between bit cycles. It is the inverse-operation companion to the full-adder cell. It gives the lab datapath a multi-bit sequential subtract with a start/done handshake, unsigned borrow and signed overflow flags. It sits between the operand registers and the result display/register stage.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// master drives start/a/b; slave returns busy/done/diff/borrow_out/ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one borrow FF between bit cycles.
// Ports: clk, rst_n (sync, active-low), bus (start/a/b in; busy/done/diff/borrow_out/ovf out).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             bw;
  logic [CW-1:0]    cnt;
  logic             sign_a;
  logic             sign_b;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bo_q;
  logic             ovf_q;

  logic             x;
  logic             y;
  logic             d;
  logic             bw_nx;
  logic [WIDTH-1:0] sr_nx;

  assign x     = sa[0];
  assign y     = sb[0];
  assign d     = x ^ y ^ bw;
  assign bw_nx = (~x & y) | (~(x ^ y) & bw);
  assign sr_nx = {d, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      bw     <= 1'b0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bo_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            sr     <= '0;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
            bw     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sr <= sr_nx;
          bw <= bw_nx;
          if (cnt == LAST) begin
            // counter parks at 0 instead of wrapping
            cnt    <= '0;
            diff_q <= sr_nx;
            bo_q   <= bw_nx;
            ovf_q  <= (sign_a != sign_b) &&
                      (sr_nx[WIDTH-1] != sign_a);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
  assign bus.ovf        = ovf_q;

endmodule
